// File: rtl/pcu_pkg.sv
// Shared types for the pipelined control unit.
// PCU_SYSTEM_EN enables the SYSTEM/FENCE drain and halt machine.
package pcu_pkg;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;
  localparam logic [6:0] OP_FENCE  = 7'b0001111;

  typedef enum logic [1:0] {
    WB_ALU = 2'b00,
    WB_MEM = 2'b01,
    WB_PC4 = 2'b10,
    WB_UPC = 2'b11
  } wb_sel_t;

  typedef enum logic [1:0] {
    ALU_ADD  = 2'b00,
    ALU_BR   = 2'b01,
    ALU_FUNC = 2'b10,
    ALU_IMM  = 2'b11
  } alu_op_t;

  typedef struct packed {
    logic    branch;
    logic    jump;
    logic    mem_read;
    logic    mem_write;
    logic    alu_src;
    logic    reg_write;
    wb_sel_t wb_sel;
    alu_op_t alu_op;
  } ctrl_t;

  localparam ctrl_t CTRL_BUBBLE = '0;

  typedef enum logic [1:0] {
    ST_RUN,
    ST_DRAIN,
    ST_HALTED
  } state_t;

endpackage

// File: rtl/pcu_if.sv
// ID-side control bundle between the core datapath and the control unit.
// master is the datapath side, slave is the control unit.
interface pcu_if #(
  parameter int REG_AW = 5
);
  import pcu_pkg::*;

  logic [31:0]       instr_id;
  logic              id_valid;
  logic              branch_taken_ex;
  logic              mem_wait;
  logic              resume;
  logic              hold_pc;
  logic              flush_ifid;
  ctrl_t             ex_ctrl;
  logic [REG_AW-1:0] ex_rd;
  ctrl_t             mem_ctrl;
  logic [REG_AW-1:0] mem_rd;
  ctrl_t             wb_ctrl;
  logic [REG_AW-1:0] wb_rd;
  logic              halted;

  modport master (
    output instr_id, id_valid,
    output branch_taken_ex, mem_wait, resume,
    input  hold_pc, flush_ifid,
    input  ex_ctrl, ex_rd,
    input  mem_ctrl, mem_rd,
    input  wb_ctrl, wb_rd,
    input  halted
  );

  modport slave (
    input  instr_id, id_valid,
    input  branch_taken_ex, mem_wait, resume,
    output hold_pc, flush_ifid,
    output ex_ctrl, ex_rd,
    output mem_ctrl, mem_rd,
    output wb_ctrl, wb_rd,
    output halted
  );

endinterface

// File: rtl/pcu_decoder.sv
// Combinational opcode decoder: instruction to control bundle.
// PCU_SYSTEM_EN adds the drain request outputs.
module pcu_decoder
  import pcu_pkg::*;
#(
  parameter int REG_AW = 5
) (
  input  logic [31:0]       instr,
  input  logic              valid,
  output ctrl_t             ctrl,
  output logic              rs1_used,
  output logic              rs2_used,
  output logic [REG_AW-1:0] rd,
  output logic [REG_AW-1:0] rs1,
  output logic [REG_AW-1:0] rs2
`ifdef PCU_SYSTEM_EN
  ,
  output logic              drain_req,
  output logic              drain_halt
`endif
);

  logic [6:0]        opc;
  logic [REG_AW-1:0] rd_f;
  logic              known;
  logic              unused_bits;

  assign opc  = instr[6:0];
  assign rd_f = instr[7 +: REG_AW];
  assign rs1  = instr[15 +: REG_AW];
  assign rs2  = instr[20 +: REG_AW];
  assign unused_bits = ^instr;

  always_comb begin
    ctrl     = CTRL_BUBBLE;
    rs1_used = 1'b0;
    rs2_used = 1'b0;
    known    = 1'b0;
    rd       = '0;
`ifdef PCU_SYSTEM_EN
    drain_req  = 1'b0;
    drain_halt = 1'b0;
`endif
    if (valid) begin
      unique case (1'b1)
        (opc == OP_R): begin
          known = 1'b1;
          ctrl.reg_write = 1'b1;
          ctrl.alu_op = ALU_FUNC;
          rs1_used = 1'b1;
          rs2_used = 1'b1;
        end
        (opc == OP_LOAD): begin
          known = 1'b1;
          ctrl.mem_read = 1'b1;
          ctrl.alu_src = 1'b1;
          ctrl.reg_write = 1'b1;
          ctrl.wb_sel = WB_MEM;
          rs1_used = 1'b1;
        end
        (opc == OP_STORE): begin
          known = 1'b1;
          ctrl.mem_write = 1'b1;
          ctrl.alu_src = 1'b1;
          rs1_used = 1'b1;
          rs2_used = 1'b1;
        end
        (opc == OP_BRANCH): begin
          known = 1'b1;
          ctrl.branch = 1'b1;
          ctrl.alu_op = ALU_BR;
          rs1_used = 1'b1;
          rs2_used = 1'b1;
        end
        (opc == OP_LUI): begin
          known = 1'b1;
          ctrl.alu_src = 1'b1;
          ctrl.reg_write = 1'b1;
          ctrl.alu_op = ALU_FUNC;
        end
        (opc == OP_JAL): begin
          known = 1'b1;
          ctrl.jump = 1'b1;
          ctrl.alu_src = 1'b1;
          ctrl.reg_write = 1'b1;
          ctrl.wb_sel = WB_PC4;
        end
        (opc == OP_JALR): begin
          known = 1'b1;
          ctrl.jump = 1'b1;
          ctrl.alu_src = 1'b1;
          ctrl.reg_write = 1'b1;
          ctrl.wb_sel = WB_PC4;
          ctrl.alu_op = ALU_FUNC;
          rs1_used = 1'b1;
        end
        (opc == OP_IMM): begin
          known = 1'b1;
          ctrl.alu_src = 1'b1;
          ctrl.reg_write = 1'b1;
          ctrl.alu_op = ALU_IMM;
          rs1_used = 1'b1;
        end
        (opc == OP_AUIPC): begin
          known = 1'b1;
          ctrl.alu_src = 1'b1;
          ctrl.reg_write = 1'b1;
          ctrl.wb_sel = WB_UPC;
        end
`ifdef PCU_SYSTEM_EN
        (opc == OP_SYSTEM): begin
          drain_req = 1'b1;
          drain_halt = 1'b1;
        end
        (opc == OP_FENCE): begin
          drain_req = 1'b1;
        end
`endif
        default: begin
        end
      endcase
      if (known) rd = rd_f;
      if (rd_f == '0) ctrl.reg_write = 1'b0;
    end
  end

endmodule

// File: rtl/pipelined_control_unit.sv
// Pipelined main controller: decode, hazards, flush, stall, drain.
// PCU_SYSTEM_EN builds the RUN/DRAIN/HALTED machine.
module pipelined_control_unit
  import pcu_pkg::*;
#(
  parameter int REG_AW       = 5,
  parameter int DRAIN_CYCLES = 3
) (
  input logic clk,
  input logic rst,
  pcu_if.slave bus
);

  ctrl_t             dec_ctrl;
  logic              rs1_used;
  logic              rs2_used;
  logic [REG_AW-1:0] id_rd;
  logic [REG_AW-1:0] id_rs1;
  logic [REG_AW-1:0] id_rs2;

  ctrl_t             ex_q;
  ctrl_t             mem_q;
  ctrl_t             wb_q;
  logic [REG_AW-1:0] ex_rd_q;
  logic [REG_AW-1:0] mem_rd_q;
  logic [REG_AW-1:0] wb_rd_q;

  logic stall;
  logic flush;
  logic hazard;
  logic ex_kill;
  logic drain_go;
  logic busy;
  logic parked;
  logic halted_q;

`ifdef PCU_SYSTEM_EN
  localparam int CW =
    (DRAIN_CYCLES < 1) ? 1 : $clog2(DRAIN_CYCLES + 1);

  state_t        state;
  logic [CW-1:0] cnt;
  logic          kind_halt;
  logic          drain_req;
  logic          drain_halt;
`endif

  pcu_decoder #(
    .REG_AW(REG_AW)
  ) u_dec (
    .instr     (bus.instr_id),
    .valid     (bus.id_valid),
    .ctrl      (dec_ctrl),
    .rs1_used  (rs1_used),
    .rs2_used  (rs2_used),
    .rd        (id_rd),
    .rs1       (id_rs1),
    .rs2       (id_rs2)
`ifdef PCU_SYSTEM_EN
    ,
    .drain_req (drain_req),
    .drain_halt(drain_halt)
`endif
  );

  assign stall = bus.mem_wait;
  assign flush = bus.branch_taken_ex;

  assign hazard = ex_q.mem_read
    && (ex_rd_q != '0)
    && ((rs1_used && (id_rs1 == ex_rd_q))
     || (rs2_used && (id_rs2 == ex_rd_q)));

`ifdef PCU_SYSTEM_EN
  assign drain_go = (state == ST_RUN)
    && drain_req && !flush && !hazard;
  assign busy   = (state != ST_RUN);
  assign parked = (state == ST_HALTED);
`else
  logic unused_resume;
  assign unused_resume = bus.resume;
  assign drain_go = 1'b0;
  assign busy     = 1'b0;
  assign parked   = 1'b0;
  assign halted_q = 1'b0;
`endif

  assign ex_kill = flush || hazard || busy || drain_go;

  assign bus.hold_pc = !rst
    && (stall || busy || (hazard && !flush));
  assign bus.flush_ifid = !rst && !stall && flush;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_q     <= CTRL_BUBBLE;
      mem_q    <= CTRL_BUBBLE;
      wb_q     <= CTRL_BUBBLE;
      ex_rd_q  <= '0;
      mem_rd_q <= '0;
      wb_rd_q  <= '0;
    end else if (!stall) begin
      if (ex_kill) begin
        ex_q    <= CTRL_BUBBLE;
        ex_rd_q <= '0;
      end else begin
        ex_q    <= dec_ctrl;
        ex_rd_q <= id_rd;
      end
      if (parked) begin
        mem_q    <= CTRL_BUBBLE;
        mem_rd_q <= '0;
        wb_q     <= CTRL_BUBBLE;
        wb_rd_q  <= '0;
      end else begin
        mem_q    <= ex_q;
        mem_rd_q <= ex_rd_q;
        wb_q     <= mem_q;
        wb_rd_q  <= mem_rd_q;
      end
    end
  end

`ifdef PCU_SYSTEM_EN
  // Counter runs only on unstalled cycles so memory waits lengthen the drain.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_RUN;
      cnt       <= '0;
      kind_halt <= 1'b0;
      halted_q  <= 1'b0;
    end else if (!stall) begin
      unique case (state)
        ST_RUN: begin
          if (drain_go) begin
            state     <= ST_DRAIN;
            cnt       <= CW'(DRAIN_CYCLES);
            kind_halt <= drain_halt;
          end
        end
        ST_DRAIN: begin
          if (cnt <= CW'(1)) begin
            cnt      <= '0;
            state    <= kind_halt ? ST_HALTED : ST_RUN;
            halted_q <= kind_halt;
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        ST_HALTED: begin
          if (bus.resume) begin
            state    <= ST_RUN;
            halted_q <= 1'b0;
          end
        end
        default: begin
          state    <= ST_RUN;
          halted_q <= 1'b0;
        end
      endcase
    end
  end
`endif

  assign bus.ex_ctrl  = ex_q;
  assign bus.ex_rd    = ex_rd_q;
  assign bus.mem_ctrl = mem_q;
  assign bus.mem_rd   = mem_rd_q;
  assign bus.wb_ctrl  = wb_q;
  assign bus.wb_rd    = wb_rd_q;
  assign bus.halted   = halted_q;

endmodule

// File: tb/tb_pipelined_control_unit.sv
// Directed bench for pipelined_control_unit.
// Drain/halt checks are built when PCU_SYSTEM_EN is defined.
module tb_pipelined_control_unit;
  import pcu_pkg::*;

  localparam logic [31:0] I_ADD3  = 32'h002081B3;
  localparam logic [31:0] I_LW5   = 32'h0000A283;
  localparam logic [31:0] I_ADD6D = 32'h00728333;
  localparam logic [31:0] I_ADD6I = 32'h00740333;
  localparam logic [31:0] I_EBRK  = 32'h00100073;
  localparam logic [31:0] I_FENCE = 32'h0FF0000F;

  localparam logic [31:0] C_R  = 32'h012;
  localparam logic [31:0] C_LW = 32'h0B4;

  localparam int NT = 11;
  localparam logic [31:0] TI [NT] = '{
    32'h002081B3, 32'h0050A023, 32'h00208063,
    32'h00001237, 32'h000000EF, 32'h000100E7,
    32'h00508393, 32'h00000013, 32'h00000497,
    32'h000001FF, 32'h002081B3
  };
  localparam logic TV [NT] = '{
    1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1,
    1'b1, 1'b1, 1'b1, 1'b1, 1'b0
  };
  localparam logic [31:0] TC [NT] = '{
    32'h012, 32'h060, 32'h201, 32'h032,
    32'h138, 32'h13A, 32'h033, 32'h023,
    32'h03C, 32'h000, 32'h000
  };
  localparam logic [31:0] TR [NT] = '{
    32'd3, 32'd0, 32'd0, 32'd4, 32'd1, 32'd1,
    32'd7, 32'd0, 32'd9, 32'd0, 32'd0
  };

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_vec = 0;
  int   n_bad = 0;

  pcu_if #(.REG_AW(5)) bus ();

  pipelined_control_unit #(
    .REG_AW      (5),
    .DRAIN_CYCLES(3)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic chk(
    input string tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h",
        tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(
    input logic [31:0] i,
    input logic v
  );
    bus.instr_id = i;
    bus.id_valid = v;
    #1;
  endtask

  function automatic logic [31:0] cv(input ctrl_t c);
    return {22'd0, c};
  endfunction

  task automatic drain_idle();
    drive(32'h0, 1'b0);
    repeat (3) tick();
  endtask

  initial begin
    bus.instr_id        = '0;
    bus.id_valid        = 1'b0;
    bus.branch_taken_ex = 1'b0;
    bus.mem_wait        = 1'b0;
    bus.resume          = 1'b0;

    repeat (2) tick();
    chk("rst_ex", cv(bus.ex_ctrl), 0);
    chk("rst_mem", cv(bus.mem_ctrl), 0);
    chk("rst_wb", cv(bus.wb_ctrl), 0);
    chk("rst_hold", bus.hold_pc, 0);
    chk("rst_flush", bus.flush_ifid, 0);
    chk("rst_halted", bus.halted, 0);
    rst = 1'b0;

    drive(I_ADD3, 1'b1);
    tick();
    drive(I_LW5, 1'b1);
    tick();
    chk("pre_rst_ex", cv(bus.ex_ctrl), C_LW);
    rst = 1'b1;
    #1;
    chk("mid_rst_ex", cv(bus.ex_ctrl), 0);
    chk("mid_rst_mem", cv(bus.mem_ctrl), 0);
    chk("mid_rst_wb", cv(bus.wb_ctrl), 0);
    chk("mid_rst_halt", bus.halted, 0);
    rst = 1'b0;
    drive(I_ADD3, 1'b1);
    tick();
    chk("add_ex", cv(bus.ex_ctrl), C_R);
    chk("add_ex_rd", bus.ex_rd, 3);
    drive(32'h0, 1'b0);
    tick();
    chk("add_mem", cv(bus.mem_ctrl), C_R);
    chk("add_mem_rd", bus.mem_rd, 3);
    tick();
    chk("add_wb", cv(bus.wb_ctrl), C_R);
    chk("add_wb_rd", bus.wb_rd, 3);

    drive(I_LW5, 1'b1);
    tick();
    drive(I_ADD6D, 1'b1);
    chk("lu_hold", bus.hold_pc, 1);
    chk("lu_flush", bus.flush_ifid, 0);
    tick();
    chk("lu_bub_ex", cv(bus.ex_ctrl), 0);
    chk("lu_bub_rd", bus.ex_rd, 0);
    chk("lu_mem", cv(bus.mem_ctrl), C_LW);
    chk("lu_hold2", bus.hold_pc, 0);
    tick();
    chk("lu_add_ex", cv(bus.ex_ctrl), C_R);
    chk("lu_add_rd", bus.ex_rd, 6);

    drive(I_LW5, 1'b1);
    tick();
    drive(I_ADD6I, 1'b1);
    chk("ind_hold", bus.hold_pc, 0);
    tick();
    chk("ind_ex", cv(bus.ex_ctrl), C_R);

    drive(I_LW5, 1'b1);
    tick();
    bus.branch_taken_ex = 1'b1;
    drive(I_ADD6D, 1'b1);
    chk("fl_flush", bus.flush_ifid, 1);
    chk("fl_hold", bus.hold_pc, 0);
    tick();
    bus.branch_taken_ex = 1'b0;
    chk("fl_ex", cv(bus.ex_ctrl), 0);

    drain_idle();
    drive(I_LW5, 1'b1);
    tick();
    drive(I_ADD6I, 1'b1);
    tick();
    bus.mem_wait = 1'b1;
    bus.branch_taken_ex = 1'b1;
    drive(I_ADD3, 1'b1);
    chk("mw_hold", bus.hold_pc, 1);
    chk("mw_flush", bus.flush_ifid, 0);
    bus.branch_taken_ex = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("mw_ex", cv(bus.ex_ctrl), C_R);
      chk("mw_mem", cv(bus.mem_ctrl), C_LW);
      chk("mw_wb", cv(bus.wb_ctrl), 0);
      chk("mw_hold_k", bus.hold_pc, 1);
    end
    bus.mem_wait = 1'b0;
    tick();
    chk("mw_go_ex_rd", bus.ex_rd, 3);
    chk("mw_go_mem_rd", bus.mem_rd, 6);
    chk("mw_go_wb", cv(bus.wb_ctrl), C_LW);
    chk("mw_go_wb_rd", bus.wb_rd, 5);

    drain_idle();
    for (int k = 0; k < NT; k++) begin
      drive(TI[k], TV[k]);
      tick();
      chk("dec_ctrl", cv(bus.ex_ctrl), TC[k]);
      chk("dec_rd", bus.ex_rd, TR[k]);
    end

    drain_idle();
`ifdef PCU_SYSTEM_EN
    drive(I_EBRK, 1'b1);
    tick();
    drive(32'h0, 1'b0);
    chk("eb_hold", bus.hold_pc, 1);
    chk("eb_ex", cv(bus.ex_ctrl), 0);
    for (int k = 0; k < 2; k++) begin
      tick();
      chk("eb_drain_halt", bus.halted, 0);
    end
    tick();
    chk("eb_halted", bus.halted, 1);
    chk("eb_halt_hold", bus.hold_pc, 1);
    tick();
    chk("eb_still", bus.halted, 1);
    bus.resume = 1'b1;
    tick();
    bus.resume = 1'b0;
    #1;
    chk("res_halted", bus.halted, 0);
    chk("res_hold", bus.hold_pc, 0);

    drive(I_EBRK, 1'b1);
    tick();
    drive(32'h0, 1'b0);
    rst = 1'b1;
    #1;
    rst = 1'b0;
    #1;
    chk("drst_hold", bus.hold_pc, 0);
    tick();
    chk("drst_halt", bus.halted, 0);
    chk("drst_hold2", bus.hold_pc, 0);

    drive(I_FENCE, 1'b1);
    tick();
    drive(32'h0, 1'b0);
    chk("fn_hold0", bus.hold_pc, 1);
    bus.branch_taken_ex = 1'b1;
    #1;
    chk("fn_br_flush", bus.flush_ifid, 1);
    tick();
    bus.branch_taken_ex = 1'b0;
    #1;
    chk("fn_hold1", bus.hold_pc, 1);
    tick();
    chk("fn_hold2", bus.hold_pc, 1);
    tick();
    chk("fn_run_hold", bus.hold_pc, 0);
    chk("fn_halted", bus.halted, 0);
    drive(I_ADD3, 1'b1);
    tick();
    chk("fn_after_ex", cv(bus.ex_ctrl), C_R);
`else
    drive(I_FENCE, 1'b1);
    chk("fn_off_hold", bus.hold_pc, 0);
    tick();
    chk("fn_off_ex", cv(bus.ex_ctrl), 0);
    chk("fn_off_hold2", bus.hold_pc, 0);
    drive(I_EBRK, 1'b1);
    bus.resume = 1'b1;
    tick();
    chk("eb_off_ex", cv(bus.ex_ctrl), 0);
    chk("eb_off_halt", bus.halted, 0);
    chk("eb_off_hold", bus.hold_pc, 0);
    bus.resume = 1'b0;
`endif

    $display("== %0d vectors applied, %0d miscompares ==",
      n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/pipelined_control_unit.md
# pipelined_control_unit

Pipelined main controller for the 5-stage RV32I core. Decodes the ID-stage instruction into a control bundle and carries it through the ID/EX, EX/MEM and MEM/WB control registers. Detects load-use hazards and inserts bubbles. Applies branch flushes and external memory stalls. Runs a drain/halt state machine for SYSTEM and FENCE instructions.

## Interface
Parameters:
- REG_AW, 5: register-address width (4 for RV32E builds).
- DRAIN_CYCLES, 3: cycles needed for ID/EX through MEM/WB to empty after a drain request.

Ports (one clock; reset is asynchronous and active-high):
- clk  in  1  core clock, rising edge.
- rst  in  1  asynchronous active-high reset.
- instr_id  in  32  instruction in ID.
- id_valid  in  1  instr_id holds a real instruction.
- branch_taken_ex  in  1  EX resolved a taken branch or jump.
- mem_wait  in  1  data memory not ready; freezes the whole pipeline.
- resume  in  1  leave HALTED (level, sampled).
- hold_pc  out  1  PC and IF/ID must not update.
- flush_ifid  out  1  IF/ID must be replaced by a bubble.
- ex_ctrl  out  10  ID/EX bundle: {branch, jump, mem_read, mem_write, alu_src, reg_write, wb_sel[1:0], alu_op[1:0]}.
- ex_rd  out  REG_AW  rd held in ID/EX.
- mem_ctrl  out  10  EX/MEM bundle.
- mem_rd  out  REG_AW  rd held in EX/MEM.
- wb_ctrl  out  10  MEM/WB bundle.
- wb_rd  out  REG_AW  rd held in MEM/WB.
- halted  out  1  core halted.

## Operation
- Decode (combinational, from opcode):
  - R-type: reg_write, alu_op=10.
  - Load: mem_read, alu_src, reg_write, wb_sel=01, alu_op=00.
  - Store: mem_write, alu_src, alu_op=00.
  - Branch: branch, alu_op=01.
  - LUI: alu_src, reg_write, alu_op=10.
  - JAL: jump, alu_src, reg_write, wb_sel=10.
  - JALR: jump, alu_src, reg_write, wb_sel=10, alu_op=10.
  - I-arith: alu_src, reg_write, alu_op=11.
  - AUIPC: alu_src, reg_write, wb_sel=11.
  - Unknown opcode, or id_valid=0: all-zero bundle (bubble).
  - rd = 0 forces reg_write = 0.
- Load-use hazard:
  - Condition: ex_ctrl.mem_read=1, ex_rd≠0, and ex_rd matches a source register the ID instruction uses (rs1 for all except LUI/AUIPC/JAL; rs2 for R-type, Store, Branch only).
  - Action: ID/EX loads a bubble; hold_pc=1 for that cycle.
- Priority each cycle: rst > mem_wait (all control registers and state hold; hold_pc=1, flush_ifid=0) > branch_taken_ex (ID/EX loads a bubble, flush_ifid=1, hazard ignored) > load-use > normal advance.
- EX/MEM and MEM/WB advance every cycle that mem_wait=0.
- State machine RUN / DRAIN / HALTED:
  - RUN → DRAIN when ID decodes SYSTEM or FENCE, id_valid=1, and no flush is active. That instruction enters ID/EX as a bubble. A drain counter loads DRAIN_CYCLES, and drain_kind records halt (ECALL/EBREAK) or fence.
  - DRAIN: hold_pc=1 and ID/EX loads bubbles. The counter decrements on cycles with mem_wait=0. When it reaches 0: fence → RUN; halt → HALTED.
  - HALTED: halted=1, hold_pc=1, all control registers are bubbles. resume=1 → RUN on the next edge.
  - branch_taken_ex arriving while in DRAIN cannot come from a younger instruction. It is still honoured: flush_ifid=1, and the drain continues.

## Timing
- Reset: ex/mem/wb ctrl and rd all 0; state RUN; counter 0; halted=0. hold_pc and flush_ifid evaluate to 0.
- The bundle for an instruction presented in ID at edge N appears on ex_ctrl after edge N+1, on mem_ctrl after N+2, and on wb_ctrl after N+3. Each mem_wait cycle adds one cycle to these.
- hold_pc and flush_ifid are combinational in the same cycle as their cause.
- Load-use costs exactly one bubble.
- A halt takes DRAIN_CYCLES edges from entering DRAIN to halted=1.
- Reset asserted mid-DRAIN or in HALTED returns to RUN immediately (asynchronously).

## Configuration
- PCU_SYSTEM_EN defined: SYSTEM/FENCE handling and the state machine as above.
- PCU_SYSTEM_EN undefined: SYSTEM and FENCE decode as bubbles; no state machine or counter is built; halted is tied to 0; resume is ignored.

## Structure
- Shared package pcu_pkg:
  - opcode constants.
  - ctrl_t packed struct (10 bits).
  - wb_sel and alu_op encodings.
  - state enum.
  - CTRL_BUBBLE constant.
- One sub-module, pcu_decoder: purely combinational; instr → ctrl_t plus rs1_used/rs2_used. The sequential logic stays in the top.

## Test plan
- Reset mid-stream: ADD x3,x1,x2 then LW issued, rst pulsed while the load is in EX → all ctrl outputs 0, state RUN, halted=0. Next: ADD x3,x1,x2 with id_valid=1 → ex_ctrl: reg_write=1, alu_op=10 one cycle later; mem_ctrl the next; wb_ctrl the next.
- Load-use: LW x5,0(x1) then ADD x6,x5,x7 → one cycle with hold_pc=1, ex_ctrl=0, ex_rd=0; the ADD reaches EX one cycle later. Same sequence with ADD x6,x8,x7 → no stall.
- Flush beats hazard: LW x5 in EX together with branch_taken_ex=1 and dependent ADD in ID → flush_ifid=1, ex_ctrl=0, hold_pc=0.
- mem_wait held 3 cycles with LW in MEM → mem_ctrl, wb_ctrl and ex_ctrl unchanged for 3 cycles, hold_pc=1, then resume advancing.
- EBREAK with DRAIN_CYCLES=3 (macro on) → hold_pc=1 immediately, halted=1 after 3 edges. resume=1 → RUN next edge, hold_pc=0.
- FENCE (macro on) → 3 drain cycles then RUN, halted stays 0. Macro off: FENCE gives ex_ctrl=0 and no hold.
